instr_encoder: RTL and testbench
================================

// Module: instr_encoder
// PURPOSE
//  Packs instruction fields (opcode, Rx, Ry, imm) into the 16-bit instruction words
//  that the CPU control decoder consumes. Writes them to consecutive instruction-memory
//  words. Buffers fields in a small FIFO and rejects illegal opcodes and out-of-range
//  immediates. Sits between the program loader (host/debug side) and instruction memory.
// PARAMETERS
//  ADDR_W      8  instruction-memory word-address width
//  FIFO_DEPTH  4  field FIFO entries; power of 2, >=2
// PORTS
//  clk          in   1       clock, all logic on rising edge
//  reset_n      in   1       synchronous, active-low reset
//  start        in   1       pulse: load base_addr, clear counters, IDLE->ACTIVE
//  base_addr    in   ADDR_W  first word address, sampled on start
//  flush        in   1       pulse: stop accepting, drain FIFO, then signal done
//  in_valid     in   1       field tuple valid
//  in_ready     out  1       encoder can accept a tuple
//  in_opcode    in   5       opcode
//  in_rx        in   3       Rx register
//  in_ry        in   3       Ry register
//  in_imm       in   11      immediate (signed)
//  mem_wr       out  1       write request to instruction memory
//  mem_ready    in   1       memory accepts write this cycle
//  mem_addr     out  ADDR_W  word address
//  mem_wdata    out  16      encoded instruction
//  err          out  1       1-cycle pulse: rejected tuple
//  err_cnt      out  8       rejected tuples, saturates at 8'hFF
//  words_written out ADDR_W  words written since start, wraps
//  done         out  1       1-cycle pulse: flush finished
//  busy         out  1       state != IDLE
// BEHAVIOUR
//  Reset (reset_n=0 at edge): state IDLE, FIFO empty, in_ready=0, mem_wr=0, mem_addr=0,
//   mem_wdata=0, err=0, err_cnt=0, words_written=0, done=0, busy=0. A pending write is dropped.
//  FSM: IDLE --start--> ACTIVE --flush--> FLUSH --(FIFO empty & !mem_wr)--> IDLE with done=1.
//   start in ACTIVE/FLUSH is ignored. flush in IDLE is ignored.
//   start and flush together in IDLE: start wins.
//  in_ready = (state==ACTIVE) && !fifo_full. A handshake occurs when in_valid && in_ready.
//  Legal opcodes:
//   00000-00101, 10000-10011, 10110, 01000-01010, 01100, 11000-11010, 11100.
//  Encoding, by opcode[4:3]:
//   00 -> {5'b0, ry, rx, op}
//   10 -> {imm[7:0], rx, op}
//   01 -> {8'b0, rx, op}
//   11 -> {imm[10:0], op}
//  Rejection:
//   Causes: illegal opcode; or opcode[4:3]==10 with imm[10:8] != {3{imm[7]}}.
//   The rejected tuple is still handshaken but not enqueued.
//   err pulses the next cycle; err_cnt increments, saturating.
//  Encoding happens at enqueue; the FIFO stores 16-bit words.
//   A word accepted at edge N can drive mem_wr at N+1 at the earliest.
//  Memory handshake:
//   mem_wr=1 whenever the FIFO is non-empty. mem_addr and mem_wdata are held stable while
//    mem_wr && !mem_ready.
//   On mem_wr && mem_ready: pop, mem_addr += 1 (wraps mod 2^ADDR_W), words_written += 1.
//  Full FIFO: in_ready=0. A simultaneous enqueue and pop on a non-full FIFO is allowed.
//   One enqueue and one pop can occur per cycle.
//  Writes continue in ACTIVE and FLUSH. No new accepts occur in FLUSH or IDLE.
// TESTING
//  1 reset: drive reset_n=0 mid-write -> all outputs at reset values, FIFO empty next cycle.
//  2 start base_addr=8'h10, send add rx=1 ry=2, mem_ready=1:
//     -> mem_wr with mem_addr=8'h10, mem_wdata=16'h0221.
//  3 mvi rx=3 imm=11'h7FF (=-1) -> 16'hFF70. addi imm=11'h080 -> err=1, err_cnt=1, no write.
//  4 j imm=11'h005 -> 16'h00B8. Opcode 5'b00110 -> err pulse, not written.
//  5 mem_ready=0 for 10 cycles, 5 tuples offered:
//     -> in_ready=0 after 4 accepted; mem_addr/mem_wdata stable.
//     -> after release, 4 words written in order.
//  6 base_addr=8'hFE, 3 words, then flush:
//     -> addresses FE, FF, 00; done pulses once after last write; busy=0.

Source files
------------

// File: rtl/instr_encoder.sv
// Packs opcode/Rx/Ry/imm tuples into 16-bit instruction words, buffers them in a
// small FIFO and streams them to consecutive instruction-memory addresses.
module instr_encoder #(
  parameter int ADDR_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        in_opcode,
  input  logic [2:0]        in_rx,
  input  logic [2:0]        in_ry,
  input  logic [10:0]       in_imm,
  output logic              mem_wr,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  output logic              err,
  output logic [7:0]        err_cnt,
  output logic [ADDR_W-1:0] words_written,
  output logic              done,
  output logic              busy,
  output logic [1:0]        state_dbg
);

  // Both ports use valid/ready: a transfer happens on a rising edge where valid and
  // ready are both high; the sender holds its payload stable until that edge.
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_FLUSH  = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic   done_d;

  logic [15:0]      fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   count;
  logic             fifo_empty, fifo_full;
  logic             tuple_ok, accept, enq, pop, start_load;

  function automatic logic op_legal(input logic [4:0] op);
    logic ok;
    ok = 1'b0;
    case (op)
      5'b00000, 5'b00001, 5'b00010, 5'b00011, 5'b00100, 5'b00101,
      5'b10000, 5'b10001, 5'b10010, 5'b10011, 5'b10110,
      5'b01000, 5'b01001, 5'b01010, 5'b01100,
      5'b11000, 5'b11001, 5'b11010, 5'b11100: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [15:0] encode(input logic [4:0] op, input logic [2:0] rx,
                                         input logic [2:0] ry, input logic [10:0] imm);
    logic [15:0] w;
    w = '0;
    case (op[4:3])
      2'b00:   w = {5'b0, ry, rx, op};
      2'b10:   w = {imm[7:0], rx, op};
      2'b01:   w = {8'b0, rx, op};
      default: w = {imm, op};
    endcase
    return w;
  endfunction

  // Opcode class 10 only carries an 8-bit immediate, so it must sign-extend cleanly.
  assign tuple_ok   = op_legal(in_opcode) &&
                      ((in_opcode[4:3] != 2'b10) || (in_imm[10:8] == {3{in_imm[7]}}));
  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == DEPTH_CNT);
  assign in_ready   = (state_q == S_ACTIVE) && !fifo_full;
  assign accept     = in_valid && in_ready;
  assign enq        = accept && tuple_ok;
  assign mem_wr     = !fifo_empty;
  assign pop        = mem_wr && mem_ready;
  assign mem_wdata  = fifo_empty ? 16'h0000 : fifo_mem[rd_ptr];
  assign start_load = (state_q == S_IDLE) && start;
  assign busy       = (state_q != S_IDLE);
  assign state_dbg  = state_q;

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE:   if (start) state_d = S_ACTIVE;
      S_ACTIVE: if (flush) state_d = S_FLUSH;
      S_FLUSH: begin
        if (fifo_empty && !mem_wr) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      mem_addr      <= '0;
      words_written <= '0;
      err           <= 1'b0;
      err_cnt       <= '0;
      done          <= 1'b0;
    end else begin
      state_q <= state_d;
      done    <= done_d;
      err     <= accept && !tuple_ok;
      if (enq) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({enq, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (start_load) begin
        mem_addr      <= base_addr;
        words_written <= '0;
        err_cnt       <= '0;
      end else begin
        if (pop) begin
          mem_addr      <= mem_addr + 1'b1;
          words_written <= words_written + 1'b1;
        end
        if (accept && !tuple_ok && (err_cnt != 8'hFF)) err_cnt <= err_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (enq) fifo_mem[wr_ptr] <= encode(in_opcode, in_rx, in_ry, in_imm);
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: directed scenarios plus randomized sessions, each cycle
// compared against a transaction-level reference model of the encoder.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start, flush, in_valid, mem_ready;
  logic [7:0]  base_addr;
  logic [4:0]  in_opcode;
  logic [2:0]  in_rx, in_ry;
  logic [10:0] in_imm;
  logic        in_ready, mem_wr, err, done, busy;
  logic [7:0]  mem_addr, err_cnt, words_written;
  logic [15:0] mem_wdata;
  logic [1:0]  state_dbg;

  instr_encoder #(.ADDR_W(8), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode), .in_rx(in_rx),
    .in_ry(in_ry), .in_imm(in_imm), .mem_wr(mem_wr), .mem_ready(mem_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .err(err), .err_cnt(err_cnt),
    .words_written(words_written), .done(done), .busy(busy), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  localparam logic [31:0] LEGAL_MASK = 32'h174F173F;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: expected FIFO contents and architectural counters.
  logic [15:0] exp_q[$];
  int          m_state;   // 0 idle, 1 active, 2 flush
  logic [7:0]  m_addr, m_written;
  int          m_errcnt;
  bit          hs_q;
  int          done_seen;
  logic [7:0]  addr_log[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
  endtask

  function automatic bit m_legal(input int op, input int imm);
    logic [31:0] mask;
    int s;
    mask = LEGAL_MASK;
    if (!mask[op]) return 1'b0;
    if (op / 8 == 2) begin
      s = (imm >= 1024) ? imm - 2048 : imm;
      if (s < -128 || s > 127) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic logic [15:0] m_encode(input int op, input int rx, input int ry, input int imm);
    int v;
    case (op / 8)
      0:       v = op + rx * 32 + ry * 256;
      1:       v = op + rx * 32;
      2:       v = op + rx * 32 + (imm % 256) * 256;
      default: v = op + imm * 32;
    endcase
    return 16'(v);
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_state  = 0;
    m_addr   = 8'h00;
    m_written = 8'h00;
    m_errcnt = 0;
  endtask

  // One clock: check pre-edge outputs, advance the model, then check post-edge pulses.
  task automatic cycle();
    bit exp_ready, pop, done_e, err_e;
    int sz;
    sz = exp_q.size();
    exp_ready = (m_state == 1) && (sz < 4);
    check("in_ready", in_ready, exp_ready);
    check("mem_wr", mem_wr, sz != 0);
    if (sz != 0) begin
      check("mem_addr", mem_addr, m_addr);
      check("mem_wdata", mem_wdata, exp_q[0]);
    end
    if (mem_wr && mem_ready) addr_log.push_back(mem_addr);
    hs_q   = in_valid && exp_ready;
    pop    = (sz != 0) && mem_ready;
    done_e = 1'b0;
    err_e  = 1'b0;
    case (m_state)
      0: if (start) begin
        m_state = 1; m_addr = base_addr; m_written = 8'h00; m_errcnt = 0;
      end
      1: if (flush) m_state = 2;
      default: if (sz == 0) begin m_state = 0; done_e = 1'b1; end
    endcase
    if (pop) begin
      void'(exp_q.pop_front());
      m_addr++;
      m_written++;
    end
    if (hs_q) begin
      if (m_legal(int'(in_opcode), int'(in_imm)))
        exp_q.push_back(m_encode(int'(in_opcode), int'(in_rx), int'(in_ry), int'(in_imm)));
      else begin
        err_e = 1'b1;
        if (m_errcnt < 255) m_errcnt++;
      end
    end
    @(posedge clk); #1;
    if (done) done_seen++;
    check("err", err, err_e);
    check("done", done, done_e);
    check("err_cnt", err_cnt, m_errcnt);
    check("words_written", words_written, m_written);
    check("busy", busy, m_state != 0);
  endtask

  task automatic set_tuple(input int op, input int rx, input int ry, input int imm);
    in_opcode = 5'(op); in_rx = 3'(rx); in_ry = 3'(ry); in_imm = 11'(imm);
  endtask

  task automatic send_one(input int op, input int rx, input int ry, input int imm);
    set_tuple(op, rx, ry, imm);
    in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    model_reset();
    @(posedge clk); #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_mem_wr", mem_wr, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_err", err, 0);
    check("rst_err_cnt", err_cnt, 0);
    check("rst_words", words_written, 0);
    check("rst_done", done, 0);
    check("rst_busy", busy, 0);
    reset_n = 1'b1;
  endtask

  task automatic do_start(input logic [7:0] base);
    base_addr = base;
    start = 1'b1;
    cycle();
    start = 1'b0;
  endtask

  task automatic flush_and_drain();
    in_valid  = 1'b0;
    mem_ready = 1'b1;
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    for (int i = 0; i < 40 && m_state != 0; i++) cycle();
    check("drain_bound", m_state == 0, 1);
  endtask

  task automatic random_session(input int ncyc);
    do_start(8'($urandom));
    for (int i = 0; i < ncyc; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      set_tuple($urandom_range(0, 31), $urandom_range(0, 7), $urandom_range(0, 7),
                ($urandom_range(0, 1) != 0) ? $urandom_range(0, 2047)
                                            : (($urandom_range(0, 255) + 1920) % 2048));
      mem_ready = ($urandom_range(0, 3) != 0);
      start     = ($urandom_range(0, 15) == 0);
      base_addr = 8'($urandom);
      cycle();
    end
    start = 1'b0;
    flush_and_drain();
  endtask

  int ops5[5] = '{1, 16, 24, 8, 3};
  int idx, acc;
  logic [7:0] w0;

  initial begin
    reset_n = 1'b0; start = 1'b0; flush = 1'b0; in_valid = 1'b0; mem_ready = 1'b1;
    base_addr = 8'h00; set_tuple(0, 0, 0, 0);
    @(posedge clk); #1;
    do_reset();

    // flush alone in IDLE is ignored; start+flush together starts the session
    flush = 1'b1; cycle();
    start = 1'b1; base_addr = 8'h10; cycle();
    start = 1'b0; flush = 1'b0;

    send_one(1, 1, 2, 0);
    check("t2_wr", mem_wr, 1); check("t2_addr", mem_addr, 8'h10); check("t2_data", mem_wdata, 16'h0221);
    send_one(16, 3, 0, 11'h7FF);
    check("t3_addr", mem_addr, 8'h11); check("t3_data", mem_wdata, 16'hFF70);
    send_one(17, 2, 0, 11'h080);
    check("t3_err", err, 1); check("t3_err_cnt", err_cnt, 1); check("t3_nowr", mem_wr, 0);
    send_one(24, 0, 0, 11'h005);
    check("t4_addr", mem_addr, 8'h12); check("t4_data", mem_wdata, 16'h00B8);
    send_one(6, 1, 1, 0);
    check("t4_err", err, 1); check("t4_err_cnt", err_cnt, 2); check("t4_nowr", mem_wr, 0);

    // back-pressure: memory stalled, five tuples offered
    mem_ready = 1'b0; idx = 0; acc = 0; w0 = words_written;
    for (int c = 0; c < 10; c++) begin
      in_valid = (idx < 5);
      set_tuple(ops5[idx % 5], idx, 7 - idx, idx * 3);
      if (in_valid && in_ready) acc++;
      cycle();
      if (hs_q) idx++;
    end
    check("t5_accepted", acc, 4);
    check("t5_full", in_ready, 0);
    in_valid = 1'b0; mem_ready = 1'b1;
    for (int c = 0; c < 6; c++) cycle();
    check("t5_words", 8'(words_written - w0), 4);
    flush_and_drain();

    // address wrap then flush completion
    do_start(8'hFE);
    addr_log.delete();
    send_one(2, 1, 1, 0); send_one(9, 4, 0, 0); send_one(28, 0, 0, 11'h3FF);
    done_seen = 0;
    flush_and_drain();
    check("t6_nwrites", addr_log.size(), 3);
    if (addr_log.size() == 3) begin
      check("t6_a0", addr_log[0], 8'hFE); check("t6_a1", addr_log[1], 8'hFF);
      check("t6_a2", addr_log[2], 8'h00);
    end
    check("t6_done_once", done_seen, 1);
    check("t6_busy", busy, 0);

    // reset while writes are pending
    do_start(8'h40);
    mem_ready = 1'b0;
    send_one(1, 2, 3, 0); send_one(4, 5, 6, 0);
    check("t1_pending", mem_wr, 1);
    do_reset();
    mem_ready = 1'b1;
    cycle();

    // err_cnt saturation
    do_start(8'h00);
    in_valid = 1'b1; set_tuple(7, 0, 0, 0);
    for (int c = 0; c < 262; c++) cycle();
    check("sat_err_cnt", err_cnt, 8'hFF);
    flush_and_drain();

    for (int s = 0; s < 4; s++) random_session(300);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule
